// File: rtl/btn_matrix_scanner.sv
// 5x5 button matrix scanner: walks one active-low row at a time and publishes a raw pressed-key map per frame.
// Optional macro GHOST_REJECT_EN withholds frames whose key pattern forms an ambiguous rectangle.
module btn_matrix_scanner #(
  parameter int ROW_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        RSTN,
  output logic [4:0]  btn_x,
  input  logic [4:0]  btn_y,
  output logic [24:0] btn_result,
  output logic        frame_done,
  output logic        ghost
);

  localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROW_CYCLES - 1);

  logic [4:0]    sync1_reg;
  logic [4:0]    sync2_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    row_reg;
  logic [4:0]    shadow_reg [4];
  logic          slot_end;
  logic          commit;
  logic [24:0]   frame;

  assign slot_end = (cnt_reg == LAST);
  assign commit   = slot_end && (row_reg == 3'd4);
  // Row 4 is taken straight from the synchronizer so the whole frame lands on one edge.
  assign frame    = {~sync2_reg, shadow_reg[3], shadow_reg[2], shadow_reg[1], shadow_reg[0]};

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync1_reg <= 5'b11111;
      sync2_reg <= 5'b11111;
      cnt_reg   <= '0;
      row_reg   <= 3'd0;
      btn_x     <= 5'b11110;
    end else begin
      sync1_reg <= btn_y;
      sync2_reg <= sync1_reg;
      if (slot_end) begin
        cnt_reg <= '0;
        row_reg <= (row_reg == 3'd4) ? 3'd0 : row_reg + 3'd1;
        btn_x   <= {btn_x[3:0], btn_x[4]};
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
          shadow_reg[gi] <= 5'b00000;
        end else if (slot_end && (row_reg == 3'(gi))) begin
          shadow_reg[gi] <= ~sync2_reg;
        end
      end
    end
  endgenerate

`ifdef GHOST_REJECT_EN
  logic ghosted;

  // Two rows sharing two pressed columns make a rectangle whose fourth corner is indistinguishable.
  always_comb begin
    logic [4:0] common;
    ghosted = 1'b0;
    common  = 5'b00000;
    for (int r1 = 0; r1 < 4; r1++) begin
      for (int r2 = r1 + 1; r2 < 5; r2++) begin
        common = frame[r1*5 +: 5] & frame[r2*5 +: 5];
        if ($countones(common) >= 2) ghosted = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      btn_result <= '0;
      frame_done <= 1'b0;
      ghost      <= 1'b0;
    end else begin
      frame_done <= commit;
      if (commit) begin
        if (ghosted) begin
          ghost <= 1'b1;
        end else begin
          ghost      <= 1'b0;
          btn_result <= frame;
        end
      end
    end
  end
`else
  assign ghost = 1'b0;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      btn_result <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
      if (commit) btn_result <= frame;
    end
  end
`endif

endmodule

// File: tb/tb_btn_matrix_scanner.sv
// Directed bench for btn_matrix_scanner with ROW_CYCLES=4 and a combinational key-matrix model.
// Expectations switch on GHOST_REJECT_EN to match the build under test.
module tb_btn_matrix_scanner;

  logic        clk;
  logic        RSTN;
  logic [4:0]  btn_x;
  logic [4:0]  btn_y;
  logic [24:0] btn_result;
  logic        frame_done;
  logic        ghost;
  logic [24:0] keys;
  int          checks;
  int          errors;

  btn_matrix_scanner #(.ROW_CYCLES(4)) dut (
    .clk        (clk),
    .RSTN       (RSTN),
    .btn_x      (btn_x),
    .btn_y      (btn_y),
    .btn_result (btn_result),
    .frame_done (frame_done),
    .ghost      (ghost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column c reads low when a driven (low) row has key (r,c) held.
  always_comb begin
    btn_y = 5'b11111;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (!btn_x[r] && keys[r*5+c]) btn_y[c] = 1'b0;
  end

  task automatic wait_frame(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_done not seen within 40 cycles", name);
    end
  endtask

  task automatic test_reset;
    logic [4:0] exp_x;
    RSTN = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (btn_x !== 5'b11110) begin errors++; $display("FAIL reset_btn_x: got %b want 11110", btn_x); end
    checks++;
    if (btn_result !== 25'h0) begin errors++; $display("FAIL reset_result: got %h want 0", btn_result); end
    checks++;
    if (frame_done !== 1'b0 || ghost !== 1'b0) begin
      errors++; $display("FAIL reset_flags: frame_done=%b ghost=%b want 0 0", frame_done, ghost);
    end
    RSTN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_x = ~(5'b00001 << ((i / 4) % 5));
      checks++;
      if (btn_x !== exp_x) begin errors++; $display("FAIL scan_btn_x[%0d]: got %b want %b", i, btn_x, exp_x); end
      checks++;
      if (frame_done !== (i == 20)) begin
        errors++; $display("FAIL first_frame_done[%0d]: got %b want %b", i, frame_done, (i == 20));
      end
    end
    checks++;
    if (btn_result !== 25'h0) begin errors++; $display("FAIL empty_frame: got %h want 0", btn_result); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single_key;
    keys = 25'h0;
    keys[13] = 1'b1;
    wait_frame("single_press");
    checks++;
    if (btn_result !== 25'h0002000) begin errors++; $display("FAIL single_press: got %h want 0002000", btn_result); end
    keys = 25'h0;
    wait_frame("single_release");
    checks++;
    if (btn_result !== 25'h0) begin errors++; $display("FAIL single_release: got %h want 0", btn_result); end
    $display("test_single_key done: result=%h", btn_result);
  endtask

  task automatic test_multi_key;
    keys = 25'h0;
    keys[0]  = 1'b1;
    keys[24] = 1'b1;
    wait_frame("corners");
    checks++;
    if (btn_result !== 25'h1000001 || ghost !== 1'b0) begin
      errors++; $display("FAIL corners: got %h ghost=%b want 1000001 ghost=0", btn_result, ghost);
    end
    keys = 25'h0;
    keys[6]  = 1'b1;
    keys[7]  = 1'b1;
    keys[16] = 1'b1;
    wait_frame("three_keys");
    checks++;
    if (btn_result !== 25'h00100C0 || ghost !== 1'b0) begin
      errors++; $display("FAIL three_keys: got %h ghost=%b want 00100c0 ghost=0", btn_result, ghost);
    end
    $display("test_multi_key done: result=%h", btn_result);
  endtask

  task automatic test_ghost;
    keys = 25'h0;
    keys[1]  = 1'b1;
    keys[2]  = 1'b1;
    keys[16] = 1'b1;
    keys[17] = 1'b1;
    wait_frame("rectangle");
`ifdef GHOST_REJECT_EN
    checks++;
    if (btn_result !== 25'h00100C0 || ghost !== 1'b1) begin
      errors++; $display("FAIL rectangle: got %h ghost=%b want 00100c0 ghost=1", btn_result, ghost);
    end
`else
    checks++;
    if (btn_result !== 25'h0030006 || ghost !== 1'b0) begin
      errors++; $display("FAIL rectangle: got %h ghost=%b want 0030006 ghost=0", btn_result, ghost);
    end
`endif
    keys[17] = 1'b0;
    wait_frame("rectangle_broken");
    checks++;
    if (btn_result !== 25'h0010006 || ghost !== 1'b0) begin
      errors++; $display("FAIL rectangle_broken: got %h ghost=%b want 0010006 ghost=0", btn_result, ghost);
    end
    $display("test_ghost done: result=%h ghost=%b", btn_result, ghost);
  endtask

  task automatic test_reset_mid_frame;
    keys = 25'h0;
    keys[5] = 1'b1;
    wait_frame("pre_reset");
    checks++;
    if (btn_result !== 25'h0000020) begin errors++; $display("FAIL pre_reset: got %h want 0000020", btn_result); end
    repeat (12) @(negedge clk);
    checks++;
    if (btn_x !== 5'b10111) begin errors++; $display("FAIL row3_driven: got %b want 10111", btn_x); end
    RSTN = 1'b0;
    #1;
    checks++;
    if (btn_result !== 25'h0 || btn_x !== 5'b11110) begin
      errors++; $display("FAIL async_reset: result=%h btn_x=%b want 0 11110", btn_result, btn_x);
    end
    @(negedge clk);
    RSTN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (frame_done !== (i == 20)) begin
        errors++; $display("FAIL restart_frame_done[%0d]: got %b want %b", i, frame_done, (i == 20));
      end
      if (i == 19) begin
        checks++;
        if (btn_result !== 25'h0) begin errors++; $display("FAIL restart_hold: got %h want 0", btn_result); end
      end
    end
    checks++;
    if (btn_result !== 25'h0000020) begin errors++; $display("FAIL restart_commit: got %h want 0000020", btn_result); end
    $display("test_reset_mid_frame done: result=%h", btn_result);
  endtask

  task automatic test_back_to_back_glitch;
    keys = 25'h0;
    keys[12] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) keys[12] = 1'b0;
      checks++;
      if (frame_done !== (i == 20)) begin
        errors++; $display("FAIL pulse_period[%0d]: got %b want %b", i, frame_done, (i == 20));
      end
    end
    checks++;
    if (btn_result !== 25'h0) begin errors++; $display("FAIL glitch_frame: got %h want 0", btn_result); end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b want 0", frame_done); end
    wait_frame("glitch_next");
    checks++;
    if (btn_result[12] !== 1'b0) begin errors++; $display("FAIL glitch_next: bit12=%b want 0", btn_result[12]); end
    $display("test_back_to_back_glitch done: result=%h", btn_result);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RSTN   = 1'b0;
    keys   = '0;
    test_reset();
    test_single_key();
    test_multi_key();
    test_ghost();
    test_reset_mid_frame();
    test_back_to_back_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
